// File: rtl/prog_loader_if.sv
// prog_loader_if -- byte-stream and memory-write bundle of the program loader.
//
// Signals:
//   in_valid   source has a byte on in_data
//   in_data    stream byte
//   in_ready   loader can accept (always high)
//   mem_we     one-cycle memory write strobe
//   mem_addr   word write address
//   mem_wdata  word write data
//   cpu_run    program loaded and verified; processor run gate
//   busy       frame in progress (LEN, DATA, CHK)
//   err        last frame rejected
//   word_cnt   words written in the current/last frame
//
// Modports:
//   master  the loader side (drives ready, memory write and status)
//   slave   the stream source / memory / processor side
interface prog_loader_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_run;
  logic          busy;
  logic          err;
  logic [AW:0]   word_cnt;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_run,
    output busy,
    output err,
    output word_cnt
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_run,
    input  busy,
    input  err,
    input  word_cnt
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- write side of the processor's instruction/data memory.
//
// Accepts a framed byte stream (SYNC, N, 4*N data bytes, XOR checksum),
// assembles big-endian 32-bit words and writes them from address 0 upward.
// cpu_run is raised only after the checksum of a complete frame matches.
//
// Ports:
//   clk1  rising-edge clock, shared with the fetch/writeback stages
//   rst   asynchronous active-high reset
//   bus   prog_loader_if.master: byte stream in, memory write and status out
module prog_loader #(
  parameter int         DEPTH = 32,
  parameter int         AW    = 5,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic           clk1,
  input  logic           rst,
  prog_loader_if.master  bus
);

  localparam int LW = AW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]    state_reg;
  logic [AW:0]   len_reg;
  logic [AW:0]   word_cnt_reg;
  logic [1:0]    byte_idx_reg;
  logic [7:0]    chk_reg;
  logic [23:0]   shift_reg;   // only the three older bytes need keeping
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [31:0]   mem_wdata_reg;

  logic          xfer;
  logic [31:0]   word_next;
  logic [AW:0]   cnt_inc;
  logic          len_bad;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign word_next = {shift_reg, bus.in_data};
  assign cnt_inc   = word_cnt_reg + LW'(1);
  // Zero length or longer than the memory; rejecting here is what keeps
  // mem_addr from ever wrapping.
  assign len_bad   = (bus.in_data == 8'd0) ||
                     ({24'd0, bus.in_data} > 32'(DEPTH));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      byte_idx_reg  <= '0;
      chk_reg       <= '0;
      shift_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      // Strobe is a single cycle; address/data hold between writes.
      mem_we_reg <= 1'b0;
      if (xfer) begin
        case (state_reg)
          S_IDLE, S_DONE, S_ERR: begin
            // Outside a frame only SYNC matters; leaving DONE drops
            // cpu_run on this same edge, before any word is rewritten.
            if (bus.in_data == SYNC) begin
              state_reg    <= S_LEN;
              word_cnt_reg <= '0;
              chk_reg      <= '0;
              byte_idx_reg <= '0;
            end
          end
          S_LEN: begin
            if (len_bad) begin
              state_reg <= S_ERR;
            end else begin
              len_reg   <= LW'(bus.in_data);
              state_reg <= S_DATA;
            end
          end
          S_DATA: begin
            shift_reg    <= word_next[23:0];
            chk_reg      <= chk_reg ^ bus.in_data;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= word_cnt_reg[AW-1:0];
              mem_wdata_reg <= word_next;
              word_cnt_reg  <= cnt_inc;
              // Last word: its write strobe lands in the first CHK cycle.
              if (cnt_inc == len_reg) begin
                state_reg <= S_CHK;
              end
            end
          end
          S_CHK: begin
            state_reg <= (bus.in_data == chk_reg) ? S_DONE : S_ERR;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Status is decoded straight from the state register, so reset clears it
  // immediately along with everything else.
  assign bus.in_ready  = 1'b1;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.word_cnt  = word_cnt_reg;
  assign bus.cpu_run   = (state_reg == S_DONE);
  assign bus.err       = (state_reg == S_ERR);
  assign bus.busy      = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                         (state_reg == S_CHK);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- self-checking bench for prog_loader.
// A byte-per-row vector table covers single-word, bad-checksum, bad-length
// and ERR->DONE recovery frames; hand-written sequences cover mid-frame
// reset, a full 32-word program and a reload with irregular valid.
module tb_prog_loader;

  logic clk1 = 1'b0;
  logic rst;

  always #5 clk1 = ~clk1;

  prog_loader_if #(.AW(5)) bus ();

  prog_loader #(
    .DEPTH (32),
    .AW    (5),
    .SYNC  (8'hA5)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        run;
    logic        busy;
    logic        err;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [4:0]  wl_addr[$];
  logic [31:0] wl_data[$];
  int          wl_cyc[$];

  always @(posedge clk1) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  always @(negedge clk1) begin
    if (bus.mem_we === 1'b1) begin
      wl_addr.push_back(bus.mem_addr);
      wl_data.push_back(bus.mem_wdata);
      wl_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic we,
                     input logic [4:0] addr, input logic [31:0] wd,
                     input logic run, input logic busy, input logic err,
                     input logic [5:0] cnt);
    vec_t r;
    r.v = v; r.d = d; r.we = we; r.addr = addr; r.wd = wd;
    r.run = run; r.busy = busy; r.err = err; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  // Called at a negedge: drive, take one posedge, return at next negedge.
  task automatic step(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
    wl_cyc.delete();
  endtask

  task automatic check_status(input string tag, input logic run,
                              input logic busy, input logic err,
                              input logic [5:0] cnt);
    chk({tag, " cpu_run"},  bus.cpu_run,  run);
    chk({tag, " busy"},     bus.busy,     busy);
    chk({tag, " err"},      bus.err,      err);
    chk({tag, " word_cnt"}, bus.word_cnt, cnt);
  endtask

  logic [7:0]  rl_bytes[10];
  logic [31:0] rl_words[2];
  int          exp_cyc[32];
  int          nlog;

  initial begin
    // -------- vector table --------
    // single word, correct checksum 12^34^56^78 = 08
    add(1, 8'hA5, 0, 0, 32'h0, 0, 1, 0, 0);
    add(1, 8'h01, 0, 0, 32'h0, 0, 1, 0, 0);
    add(1, 8'h12, 0, 0, 32'h0, 0, 1, 0, 0);
    add(1, 8'h34, 0, 0, 32'h0, 0, 1, 0, 0);
    add(1, 8'h56, 0, 0, 32'h0, 0, 1, 0, 0);
    add(1, 8'h78, 1, 0, 32'h12345678, 0, 1, 0, 1);
    add(1, 8'h08, 0, 0, 32'h12345678, 1, 0, 0, 1);
    add(0, 8'h08, 0, 0, 32'h12345678, 1, 0, 0, 1);
    // bad checksum: DE^AD^BE^EF = 22, sent 00
    add(1, 8'hA5, 0, 0, 32'h12345678, 0, 1, 0, 0);
    add(1, 8'h01, 0, 0, 32'h12345678, 0, 1, 0, 0);
    add(1, 8'hDE, 0, 0, 32'h12345678, 0, 1, 0, 0);
    add(1, 8'hAD, 0, 0, 32'h12345678, 0, 1, 0, 0);
    add(1, 8'hBE, 0, 0, 32'h12345678, 0, 1, 0, 0);
    add(1, 8'hEF, 1, 0, 32'hDEADBEEF, 0, 1, 0, 1);
    add(1, 8'h00, 0, 0, 32'hDEADBEEF, 0, 0, 1, 1);
    add(1, 8'h33, 0, 0, 32'hDEADBEEF, 0, 0, 1, 1);
    // bad lengths 00 and 21
    add(1, 8'hA5, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0);
    add(1, 8'hA5, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'h21, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0);
    // recovery from ERR: AA^BB^CC^DD = 00
    add(1, 8'hA5, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'h01, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'hAA, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'hBB, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'hCC, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(1, 8'hDD, 1, 0, 32'hAABBCCDD, 0, 1, 0, 1);
    add(1, 8'h00, 0, 0, 32'hAABBCCDD, 1, 0, 0, 1);
    // N == DEPTH accepted; partial second word before reset
    add(1, 8'hA5, 0, 0, 32'hAABBCCDD, 0, 1, 0, 0);
    add(1, 8'h20, 0, 0, 32'hAABBCCDD, 0, 1, 0, 0);
    add(1, 8'h11, 0, 0, 32'hAABBCCDD, 0, 1, 0, 0);
    add(1, 8'h22, 0, 0, 32'hAABBCCDD, 0, 1, 0, 0);
    add(1, 8'h33, 0, 0, 32'hAABBCCDD, 0, 1, 0, 0);
    add(1, 8'h44, 1, 0, 32'h11223344, 0, 1, 0, 1);
    add(1, 8'h55, 0, 0, 32'h11223344, 0, 1, 0, 1);

    // -------- reset state --------
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk1);
    chk("reset in_ready",  bus.in_ready,  1'b1);
    chk("reset mem_we",    bus.mem_we,    1'b0);
    chk("reset mem_addr",  bus.mem_addr,  5'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);
    check_status("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // -------- table run --------
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d);
      $display("row %0d: in %b/%h -> we=%b addr=%0d wd=%h run=%b busy=%b err=%b cnt=%0d",
               i, tbl[i].v, tbl[i].d, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.cpu_run, bus.busy, bus.err, bus.word_cnt);
      chk($sformatf("row%0d in_ready", i),  bus.in_ready,  1'b1);
      chk($sformatf("row%0d mem_we", i),    bus.mem_we,    tbl[i].we);
      chk($sformatf("row%0d mem_addr", i),  bus.mem_addr,  tbl[i].addr);
      chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata, tbl[i].wd);
      check_status($sformatf("row%0d", i), tbl[i].run, tbl[i].busy,
                   tbl[i].err, tbl[i].cnt);
    end

    // -------- reset mid-DATA (2nd byte of word 1 presented) --------
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #2 rst = 1'b1;
    #1;
    $display("midreset: we=%b addr=%0d wd=%h busy=%b cnt=%0d",
             bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.word_cnt);
    chk("midreset mem_we",    bus.mem_we,    1'b0);
    chk("midreset mem_addr",  bus.mem_addr,  5'd0);
    chk("midreset mem_wdata", bus.mem_wdata, 32'h0);
    chk("midreset in_ready",  bus.in_ready,  1'b1);
    check_status("midreset", 0, 0, 0, 0);
    @(negedge clk1);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // -------- full program with leading noise --------
    clear_log();
    step(1, 8'h00);
    step(1, 8'hFF);
    chk("noise busy", bus.busy, 1'b0);
    step(1, 8'hA5);
    step(1, 8'h20);
    for (int w = 0; w < 32; w++) begin
      for (int b = 0; b < 4; b++) begin
        step(1, (b == 3) ? 8'(w) : 8'h00);
        if (b == 3) exp_cyc[w] = cyc;
      end
    end
    step(1, 8'h00);
    step(0, 8'h00);
    $display("full: writes=%0d run=%b cnt=%0d", wl_addr.size(), bus.cpu_run,
             bus.word_cnt);
    chk("full write count", wl_addr.size(), 32);
    nlog = (wl_addr.size() < 32) ? wl_addr.size() : 32;
    for (int k = 0; k < nlog; k++) begin
      chk($sformatf("full w%0d addr", k), wl_addr[k], k);
      chk($sformatf("full w%0d data", k), wl_data[k], k);
      chk($sformatf("full w%0d latency", k), wl_cyc[k], exp_cyc[k]);
      if (k > 0) chk($sformatf("full w%0d spacing", k),
                     wl_cyc[k] - wl_cyc[k-1], 4);
    end
    check_status("full end", 1, 0, 0, 32);

    // -------- reload from DONE with irregular valid --------
    // words 01A50203, 04050607; checksum = A5
    rl_bytes = '{8'h02, 8'h01, 8'hA5, 8'h02, 8'h03,
                 8'h04, 8'h05, 8'h06, 8'h07, 8'hA5};
    rl_words = '{32'h01A50203, 32'h04050607};
    clear_log();
    step(1, 8'hA5);
    chk("reload sync cpu_run", bus.cpu_run, 1'b0);
    chk("reload sync busy", bus.busy, 1'b1);
    chk("reload sync word_cnt", bus.word_cnt, 6'd0);
    for (int i = 0; i < 10; i++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--)
        step(0, 8'($urandom));
      step(1, rl_bytes[i]);
      if (i < 9) chk($sformatf("reload b%0d cpu_run", i), bus.cpu_run, 1'b0);
    end
    step(0, 8'h00);
    $display("reload: writes=%0d run=%b cnt=%0d", wl_addr.size(),
             bus.cpu_run, bus.word_cnt);
    chk("reload write count", wl_addr.size(), 2);
    nlog = (wl_addr.size() < 2) ? wl_addr.size() : 2;
    for (int k = 0; k < nlog; k++) begin
      chk($sformatf("reload w%0d addr", k), wl_addr[k], k);
      chk($sformatf("reload w%0d data", k), wl_data[k], rl_words[k]);
    end
    check_status("reload end", 1, 0, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
